// File: rtl/wave_div_sequencer.sv
// wave_div_sequencer: debounced button/sweep control that hands clamped divider values to the tone generator
// over a load/ack handshake.
module wave_div_sequencer #(
    parameter int DEBOUNCE_CYC = 500000,
    parameter int DIV_MIN      = 5000,
    parameter int DIV_MAX      = 100000,
    parameter int DIV_STEP     = 10000,
    parameter int DIV_RESET    = 50000,
    parameter int SWEEP_DWELL  = 25000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_inc,
    input  logic        btn_dec,
    input  logic        btn_mode,
    input  logic        div_ack,
    output logic [31:0] div_val,
    output logic        div_load,
    output logic        sweep_active,
    output logic        busy
);
    localparam int DBW = $clog2(DEBOUNCE_CYC + 1);
    localparam int DWW = $clog2(SWEEP_DWELL + 1);
    localparam logic [31:0] MN = 32'(DIV_MIN);
    localparam logic [31:0] MX = 32'(DIV_MAX);
    localparam logic [31:0] ST = 32'(DIV_STEP);
    localparam logic [31:0] RS = 32'(DIV_RESET);

    typedef enum logic [1:0] {INIT, IDLE, UPDATE, LOAD} state_t;

    logic [2:0]     btn, s1, s2, acc, ev;
    logic [DBW-1:0] cnt [3];
    logic [32:0]    add;
    logic [31:0]    dn, up, target;
    logic [DWW-1:0] dwell;
    logic           sweep_dir;
    state_t         state;

    assign btn = {btn_mode, btn_dec, btn_inc};

    // bit 0 = inc, bit 1 = dec, bit 2 = mode; ev pulses on an accepted rising level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1  <= '0;
            s2  <= '0;
            acc <= '0;
            ev  <= '0;
            for (int i = 0; i < 3; i++) cnt[i] <= '0;
        end else begin
            s1 <= btn;
            s2 <= s1;
            for (int i = 0; i < 3; i++) begin
                ev[i] <= 1'b0;
                if (s2[i] == acc[i]) cnt[i] <= '0;
                else if (cnt[i] == DBW'(DEBOUNCE_CYC)) begin
                    acc[i] <= s2[i];
                    ev[i]  <= s2[i];
                    cnt[i] <= '0;
                end else cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end

    // 33-bit headroom so neither direction can wrap before clamping
    assign add = {1'b0, div_val} + {1'b0, ST};
    assign up  = (add > {1'b0, MX}) ? MX : add[31:0];
    assign dn  = ({1'b0, div_val} < {1'b0, MN} + {1'b0, ST}) ? MN : div_val - ST;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= INIT;
            div_val      <= RS;
            target       <= RS;
            div_load     <= 1'b0;
            sweep_active <= 1'b0;
            sweep_dir    <= 1'b0;
            busy         <= 1'b0;
            dwell        <= '0;
        end else begin
            case (state)
                INIT: begin
                    div_val  <= RS;
                    div_load <= 1'b1;
                    busy     <= 1'b1;
                    state    <= LOAD;
                end
                IDLE:
                    if (!sweep_active) begin
                        if (ev[0] ^ ev[1]) begin
                            target <= ev[0] ? dn : up;
                            busy   <= 1'b1;
                            state  <= UPDATE;
                        end
                    end else if (dwell == DWW'(SWEEP_DWELL - 1)) begin
                        dwell  <= '0;
                        target <= sweep_dir ? up : dn;
                        busy   <= 1'b1;
                        state  <= UPDATE;
                    end else dwell <= dwell + 1'b1;
                UPDATE: begin
                    // reverse even when already parked on a limit so the sweep cannot stall there
                    if (sweep_active && target == MN) sweep_dir <= 1'b1;
                    if (sweep_active && target == MX) sweep_dir <= 1'b0;
                    if (target == div_val) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        div_val  <= target;
                        div_load <= 1'b1;
                        state    <= LOAD;
                    end
                end
                default:
                    if (div_ack) begin
                        div_load <= 1'b0;
                        busy     <= 1'b0;
                        dwell    <= '0;
                        state    <= IDLE;
                    end
            endcase
            if (ev[2]) begin
                sweep_active <= !sweep_active;
                if (!sweep_active) begin
                    sweep_dir <= 1'b0;
                    dwell     <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_wave_div_sequencer.sv
// tb_wave_div_sequencer: randomized and directed checks of wave_div_sequencer against a transaction-level model
// of the divider loads it should issue.
module tb_wave_div_sequencer;
    localparam int D  = 4;
    localparam int MN = 10;
    localparam int MX = 50;
    localparam int ST = 10;
    localparam int RS = 30;
    localparam int DW = 20;

    logic clk = 1'b0, rst = 1'b1;
    logic btn_inc = 1'b0, btn_dec = 1'b0, btn_mode = 1'b0, div_ack = 1'b0;
    logic [31:0] div_val;
    logic div_load, sweep_active, busy;
    logic ack_en = 1'b1, ack_fast = 1'b0, load_seen = 1'b0, prev_load = 1'b0;
    int passed = 0, total = 0, cyc_cnt = 0, mv = RS;
    int lq[$], ts[$], eq[$];

    wave_div_sequencer #(
        .DEBOUNCE_CYC(D), .DIV_MIN(MN), .DIV_MAX(MX), .DIV_STEP(ST),
        .DIV_RESET(RS), .SWEEP_DWELL(DW)
    ) dut (
        .clk(clk), .rst(rst), .btn_inc(btn_inc), .btn_dec(btn_dec), .btn_mode(btn_mode),
        .div_ack(div_ack), .div_val(div_val), .div_load(div_load),
        .sweep_active(sweep_active), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // generator stand-in: acks one cycle after a load (or at once in fast mode) and logs every new load
    always @(negedge clk) begin
        div_ack = ack_en && div_load && (ack_fast || load_seen);
        load_seen = div_load;
        if (div_load && !prev_load) begin
            lq.push_back(int'(div_val));
            ts.push_back(cyc_cnt);
        end
        prev_load = div_load;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [2:0] m, input int hi, input int lo);
        {btn_mode, btn_dec, btn_inc} = m;
        cyc(hi);
        {btn_mode, btn_dec, btn_inc} = 3'b000;
        cyc(lo);
    endtask

    function automatic int step(input int v, input logic raise);
        if (raise) return (v + ST > MX) ? MX : v + ST;
        return (v - ST < MN) ? MN : v - ST;
    endfunction

    task automatic manual(input logic raise);
        int nv;
        nv = step(mv, raise);
        if (nv != mv) eq.push_back(nv);
        mv = nv;
    endtask

    task automatic compare_loads(input string tag);
        check({tag, "_count"}, lq.size(), eq.size());
        for (int i = 0; i < lq.size() && i < eq.size(); i++) check(tag, lq[i], eq[i]);
        lq.delete();
        ts.delete();
        eq.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t0, n, v, r;
        logic dir;
        logic [2:0] m;
        cyc(3);
        check("rst_val", div_val, RS);
        check("rst_load", div_load, 0);
        check("rst_sweep", sweep_active, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);
        check("init_load", div_load, 1);
        check("init_val", div_val, RS);
        check("init_busy", busy, 1);
        #2 rst = 1'b1;
        #1 check("rst_async_load", div_load, 0);
        check("rst_async_busy", busy, 0);
        ack_fast = 1'b1;
        @(negedge clk) rst = 1'b0;
        @(negedge clk) check("reload", div_load, 1);
        @(negedge clk) check("fast_ack", div_load, 0);
        ack_fast = 1'b0;
        eq.push_back(RS);
        eq.push_back(RS);
        compare_loads("init");

        repeat (3) begin
            press(3'b001, 12, 12);
            manual(1'b0);
        end
        check("floor_val", div_val, mv);
        repeat (5) begin
            press(3'b010, 12, 12);
            manual(1'b1);
        end
        check("ceil_val", div_val, mv);
        compare_loads("manual");

        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(6);
        mv = RS;
        eq.push_back(RS);
        compare_loads("reinit");

        ack_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            btn_inc = 1'b1;
            cyc(2);
            btn_inc = 1'b0;
            cyc(2);
        end
        btn_inc = 1'b1;
        t0 = cyc_cnt;
        cyc(12);
        btn_dec = 1'b1;
        cyc(12);
        btn_dec = 1'b0;
        cyc(30);
        manual(1'b0);
        check("held_load", div_load, 1);
        check("held_val", div_val, mv);
        check("held_busy", busy, 1);
        ack_en = 1'b1;
        cyc(4);
        check("held_release", div_load, 0);
        check("deb_time", (ts.size() > 0) ? ts[0] : -1, t0 + 1 + D + 4);
        btn_inc = 1'b0;
        cyc(2);
        btn_inc = 1'b1;
        cyc(12);
        btn_inc = 1'b0;
        cyc(12);
        compare_loads("debounce");

        press(3'b011, 12, 12);
        check("simul_val", div_val, mv);
        compare_loads("simul");

        press(3'b010, 12, 12);
        manual(1'b1);
        compare_loads("pre_sweep");
        press(3'b100, 12, 12);
        check("sweep_on", sweep_active, 1);
        cyc(40);
        press(3'b001, 12, 12);
        cyc(100);
        press(3'b100, 12, 12);
        check("sweep_off", sweep_active, 0);
        n = lq.size();
        cyc(100);
        check("sweep_stopped", lq.size(), n);
        check("sweep_len", n >= 7, 1);
        for (int i = 1; i < ts.size(); i++) check("sweep_gap", ts[i] - ts[i-1], DW + 2 + 1);
        v = mv;
        dir = 1'b0;
        for (int i = 0; i < n; i++) begin
            v = step(v, dir);
            if (v == MN) dir = 1'b1;
            if (v == MX) dir = 1'b0;
            eq.push_back(v);
        end
        mv = v;
        compare_loads("sweep");
        check("sweep_end_val", div_val, mv);

        for (int k = 0; k < 12; k++) begin
            r = $urandom_range(0, 4);
            m = (r == 4) ? 3'b011 : (r[0] ? 3'b001 : 3'b010);
            press(m, D + 4 + $urandom_range(0, 8), D + 4 + $urandom_range(0, 8));
            if (m != 3'b011) manual(m == 3'b010);
        end
        cyc(10);
        compare_loads("random");
        check("random_val", div_val, mv);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/wave_div_sequencer.md
# wave_div_sequencer

Control block that sits in front of the square-wave tone generator and owns its 32-bit divider setting. It debounces the inc/dec/mode push-buttons and computes a clamped new divider from manual steps or an automatic triangle sweep. It delivers each new value to the generator over a load/ack handshake. The generator only ever receives divider values that are in range and stable while the load is pending.

## Interface
- DEBOUNCE_CYC, 500000: stable cycles required to accept a button level (10 ms at 50 MHz); must be ≥ 2.
- DIV_MIN, 5000: lowest legal divider (highest frequency).
- DIV_MAX, 100000: highest legal divider (lowest frequency).
- DIV_STEP, 10000: divider change per step.
- DIV_RESET, 50000: divider after reset; DIV_MIN ≤ DIV_RESET ≤ DIV_MAX.
- SWEEP_DWELL, 25000000: cycles between sweep steps (0.5 s).
- clk  input  1  single system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- btn_inc  input  1  raw button, asynchronous; press raises frequency (lowers divider).
- btn_dec  input  1  raw button, asynchronous; press lowers frequency (raises divider).
- btn_mode  input  1  raw button, asynchronous; press toggles manual/sweep mode.
- div_ack  input  1  generator acknowledge of div_load.
- div_val  output  32  divider value presented to generator.
- div_load  output  1  request: div_val valid, held until acked.
- sweep_active  output  1  1 = sweep mode.
- busy  output  1  high in UPDATE or LOAD.

## Operation
- Each button path: 2-flop synchronizer → debouncer. The accepted level changes only after the synced level differs from it for DEBOUNCE_CYC consecutive cycles. A mismatch break restarts the count. A 0→1 change of the accepted level produces a 1-cycle press event.
- FSM states:
  - INIT (reset state) → LOAD with div_val = DIV_RESET, so the generator syncs after every reset.
  - IDLE: waits for events.
  - UPDATE: computes next value; 1 cycle.
  - LOAD: div_load = 1 until div_ack.
- IDLE, manual mode:
  - inc event alone → UPDATE with target = max(div_val − DIV_STEP, DIV_MIN).
  - dec event alone → UPDATE with target = min(div_val + DIV_STEP, DIV_MAX).
  - inc and dec events in the same cycle → both ignored.
- IDLE, sweep mode: inc/dec events ignored. The dwell counter counts to SWEEP_DWELL−1 and then triggers UPDATE in sweep_dir.
  - sweep_dir = 0: divider decreasing.
  - On reaching DIV_MIN, sweep_dir ← 1. On reaching DIV_MAX, sweep_dir ← 0.
  - The reversal is applied in the same UPDATE that lands on the limit.
- Mode event in any state toggles sweep_active. On entering sweep: sweep_dir ← 0 and the dwell counter clears.
- UPDATE: if target == current div_val (already at limit), return to IDLE with no load. Otherwise div_val ← target and go to LOAD.
- LOAD: div_val frozen. On div_ack sampled high: div_load drops next edge, state → IDLE, dwell counter clears.
- Events other than mode arriving in UPDATE or LOAD are dropped; there is no queue.
- Arithmetic is 33-bit to avoid wrap. div_val never leaves [DIV_MIN, DIV_MAX].

## Timing
- Reset values:
  - div_val = DIV_RESET, div_load = 0, sweep_active = 0, busy = 0.
  - Debouncers accepted = 0; counters = 0; state = INIT.
- First edge after rst release: INIT → LOAD; div_load = 1 at edge 1.
- Press latency: btn high sampled at edge 0 with no bounce → accepted level and event at edge DEBOUNCE_CYC+2 → UPDATE → div_load high at edge DEBOUNCE_CYC+4.
- div_ack is sampled only while div_load = 1. div_ack high in the same cycle that div_load first rises completes the handshake, so div_load is high for exactly 1 cycle. div_ack while idle is ignored.
- Sweep period = SWEEP_DWELL + 2 + ack latency cycles per step.
- rst mid-LOAD: div_load drops immediately (async), div_val → DIV_RESET, and a fresh INIT load follows.
- A held button produces one event only. A release shorter than DEBOUNCE_CYC is not a new press.

## Test plan
Bench parameters: DEBOUNCE_CYC=4, DIV_MIN=10, DIV_MAX=50, DIV_STEP=10, DIV_RESET=30, SWEEP_DWELL=20; div_ack is returned 1 cycle after div_load.

- **Reset/init:** release rst → div_load pulses with div_val=30 at edge 1; assert rst during that load → div_load=0 asynchronously, then reloads 30.
- **Manual steps:** two clean inc presses → loads of 20, then 10; a third inc → no div_load, div_val stays 10. Five dec presses → 20, 30, 40, 50, then no load.
- **Debounce:** btn_inc toggled high/low every 2 cycles for 20 cycles, then held high → exactly one load (20), at DEBOUNCE_CYC+4 cycles after the final rise.
- **Simultaneous/busy:** inc and dec events in the same cycle → no load. With div_ack withheld for 50 cycles, a dec press during LOAD → dropped; div_val holds 20 until ack.
- **Sweep:** mode press from 30 → loads 20, 10, 20, 30, 40, 50, 40, … with ≥20 idle cycles between loads; inc presses during sweep cause no loads; a second mode press stops the sweep.
